mem_access: RTL and testbench



---
 rtl/mem_access.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: load/store over a single-outstanding req/ack data bus,
// with lane alignment, byte enables, address-error detection and stall control.
package mem_access_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_ALU,
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
        OP_SB, OP_SH, OP_SW
    } Oper_t;

    typedef logic [4:0] Reg_addr_t;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int DBUS_AW        = 32,
    parameter bit STALL_ON_DRAIN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  Oper_t              mem_oper,
    input  logic [31:0]        mem_mem_oper_addr,
    input  logic [31:0]        mem_mem_oper_data,
    input  logic               mem_wreg_write,
    input  Reg_addr_t          mem_wreg_addr,
    input  logic [31:0]        mem_wreg_data,
    input  logic [31:0]        mem_pc,
    input  logic               flush,
    output logic               wb_wreg_write,
    output Reg_addr_t          wb_wreg_addr,
    output logic [31:0]        wb_wreg_data,
    output logic               excp_adel,
    output logic               excp_ades,
    output logic [31:0]        bad_vaddr,
    output logic               stallreq_mem,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [3:0]         dbus_be,
    output logic [DBUS_AW-1:0] dbus_addr,
    output logic [31:0]        dbus_wdata,
    input  logic [31:0]        dbus_rdata,
    input  logic               dbus_ack
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_DRAIN} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t state_q, state_d;

    logic               is_load, is_store, is_mem, misaligned;
    size_t              size;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic               latch_en, capture_en;

    logic               we_q;
    logic [3:0]         be_q;
    logic [DBUS_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    Oper_t              oper_q;
    logic [1:0]         off_q;
    logic               wreg_write_q;
    Reg_addr_t          wreg_addr_q;
    logic [31:0]        rdata_q;

    // The PC is carried for the pipeline record only; nothing in this stage consumes it.
    logic unused_pc;
    assign unused_pc = ^mem_pc;

    function automatic logic [31:0] load_align(Oper_t op, logic [1:0] off, logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{off, 3'b000} +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = SZ_WORD;
        case (mem_oper)
            OP_LB, OP_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
            OP_LW:         begin is_load  = 1'b1; size = SZ_WORD; end
            OP_SB:         begin is_store = 1'b1; size = SZ_BYTE; end
            OP_SH:         begin is_store = 1'b1; size = SZ_HALF; end
            OP_SW:         begin is_store = 1'b1; size = SZ_WORD; end
            default: ;
        endcase
        is_mem = is_load | is_store;

        case (size)
            SZ_BYTE: begin
                misaligned = 1'b0;
                be_c       = 4'b0001 << mem_mem_oper_addr[1:0];
                wdata_c    = {4{mem_mem_oper_data[7:0]}};
            end
            SZ_HALF: begin
                misaligned = mem_mem_oper_addr[0];
                be_c       = mem_mem_oper_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{mem_mem_oper_data[15:0]}};
            end
            default: begin
                misaligned = |mem_mem_oper_addr[1:0];
                be_c       = 4'b1111;
                wdata_c    = mem_mem_oper_data;
            end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        dbus_req      = 1'b0;
        dbus_we       = 1'b0;
        dbus_be       = 4'b0000;
        dbus_addr     = '0;
        dbus_wdata    = '0;
        stallreq_mem  = 1'b0;
        wb_wreg_write = 1'b0;
        wb_wreg_addr  = mem_wreg_addr;
        wb_wreg_data  = mem_wreg_data;
        excp_adel     = 1'b0;
        excp_ades     = 1'b0;
        bad_vaddr     = mem_mem_oper_addr;
        latch_en      = 1'b0;
        capture_en    = 1'b0;

        // Once issued, the request is replayed from the latched copy so the bus sees it stable.
        if (state_q == S_WAIT || state_q == S_DRAIN) begin
            dbus_req   = 1'b1;
            dbus_we    = we_q;
            dbus_be    = be_q;
            dbus_addr  = addr_q;
            dbus_wdata = wdata_q;
        end

        case (state_q)
            S_IDLE: begin
                if (is_mem && !flush) begin
                    if (misaligned) begin
                        excp_adel = is_load;
                        excp_ades = is_store;
                    end else begin
                        dbus_req   = 1'b1;
                        dbus_we    = is_store;
                        dbus_be    = be_c;
                        dbus_addr  = {mem_mem_oper_addr[DBUS_AW-1:2], 2'b00};
                        dbus_wdata = wdata_c;
                        if (dbus_ack) begin
                            wb_wreg_write = is_load & mem_wreg_write;
                            wb_wreg_data  = load_align(mem_oper, mem_mem_oper_addr[1:0], dbus_rdata);
                        end else begin
                            stallreq_mem = 1'b1;
                            latch_en     = 1'b1;
                            state_d      = S_WAIT;
                        end
                    end
                end else begin
                    wb_wreg_write = mem_wreg_write & ~is_mem & ~flush;
                end
            end
            S_WAIT: begin
                stallreq_mem = 1'b1;
                if (dbus_ack) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        capture_en = 1'b1;
                        state_d    = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                wb_wreg_write = wreg_write_q & ~flush;
                wb_wreg_addr  = wreg_addr_q;
                wb_wreg_data  = rdata_q;
                state_d       = S_IDLE;
            end
            S_DRAIN: begin
                if (dbus_ack) state_d = S_IDLE;
                if (is_mem) stallreq_mem = STALL_ON_DRAIN;
                else        wb_wreg_write = mem_wreg_write & ~flush;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset withdraws the request at once; the bus tolerates the abort.
        if (!rst) begin
            dbus_req     = 1'b0;
            stallreq_mem = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the latched request/data registers are reset too, so DRAIN/DONE never replay stale contents after reset.
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            be_q         <= 4'b0000;
            addr_q       <= '0;
            wdata_q      <= '0;
            oper_q       <= OP_NOP;
            off_q        <= 2'b00;
            wreg_write_q <= 1'b0;
            wreg_addr_q  <= '0;
            rdata_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (latch_en) begin
                we_q         <= is_store;
                be_q         <= be_c;
                addr_q       <= {mem_mem_oper_addr[DBUS_AW-1:2], 2'b00};
                wdata_q      <= wdata_c;
                oper_q       <= mem_oper;
                off_q        <= mem_mem_oper_addr[1:0];
                wreg_write_q <= is_load & mem_wreg_write;
                wreg_addr_q  <= mem_wreg_addr;
            end
            if (capture_en) rdata_q <= load_align(oper_q, off_q, dbus_rdata);
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: single-cycle vector table, multi-cycle
// corner sequences, and randomized transactions against a transaction-level model.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    Oper_t       mem_oper;
    logic [31:0] mem_mem_oper_addr, mem_mem_oper_data, mem_wreg_data, mem_pc;
    logic        mem_wreg_write, flush;
    Reg_addr_t   mem_wreg_addr;
    logic        wb_wreg_write, excp_adel, excp_ades, stallreq_mem;
    Reg_addr_t   wb_wreg_addr;
    logic [31:0] wb_wreg_data, bad_vaddr;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;

    int n_vec = 0;
    int n_err = 0;

    mem_access #(.DBUS_AW(32), .STALL_ON_DRAIN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .mem_oper(mem_oper), .mem_mem_oper_addr(mem_mem_oper_addr),
        .mem_mem_oper_data(mem_mem_oper_data), .mem_wreg_write(mem_wreg_write),
        .mem_wreg_addr(mem_wreg_addr), .mem_wreg_data(mem_wreg_data), .mem_pc(mem_pc),
        .flush(flush),
        .wb_wreg_write(wb_wreg_write), .wb_wreg_addr(wb_wreg_addr), .wb_wreg_data(wb_wreg_data),
        .excp_adel(excp_adel), .excp_ades(excp_ades), .bad_vaddr(bad_vaddr),
        .stallreq_mem(stallreq_mem),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_be(dbus_be), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input Oper_t op, input logic [31:0] a, input logic [31:0] d,
                         input logic wr, input logic [31:0] wd, input logic fl,
                         input logic ack, input logic [31:0] rd);
        mem_oper          = op;
        mem_mem_oper_addr = a;
        mem_mem_oper_data = d;
        mem_wreg_write    = wr;
        mem_wreg_addr     = 5'd7;
        mem_wreg_data     = wd;
        mem_pc            = 32'hBFC0_0000;
        flush             = fl;
        dbus_ack          = ack;
        dbus_rdata        = rd;
    endtask

    // Reference model: loads pick a lane by shifting and extend by width/sign.
    function automatic logic [31:0] ref_load(Oper_t op, logic [31:0] a, logic [31:0] rd);
        logic [31:0] lane;
        lane = rd >> (8 * a[1:0]);
        case (op)
            OP_LB:   return 32'($signed(lane[7:0]));
            OP_LBU:  return lane & 32'h0000_00FF;
            OP_LH:   return 32'($signed(lane[15:0]));
            OP_LHU:  return lane & 32'h0000_FFFF;
            default: return rd;
        endcase
    endfunction

    function automatic int op_bytes(Oper_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    typedef struct {
        Oper_t       op;
        logic [31:0] addr, data, rdata;
        logic        ack, fl;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_wb;
        logic [31:0] e_wbdata;
        logic        e_adel, e_ades;
    } vec_t;

    vec_t vt[15];
    Oper_t ops[10];

    initial begin
        vt[0]  = '{OP_LW,  32'h1000, 32'h0,        32'hDEADBEEF, 1, 0, 1, 0, 4'hF, 32'h0,        1, 32'hDEADBEEF, 0, 0};
        vt[1]  = '{OP_SB,  32'h2003, 32'h0000_00A5, 32'h0,       1, 0, 1, 1, 4'h8, 32'hA5A5A5A5, 0, 32'h0,        0, 0};
        vt[2]  = '{OP_LW,  32'h3002, 32'h0,        32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        0, 32'h0,        1, 0};
        vt[3]  = '{OP_SH,  32'h3001, 32'h0,        32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 1};
        vt[4]  = '{OP_LB,  32'h1001, 32'h0,        32'h0000_8000, 1, 0, 1, 0, 4'h2, 32'h0,       1, 32'hFFFFFF80, 0, 0};
        vt[5]  = '{OP_LBU, 32'h1003, 32'h0,        32'hF100_0000, 1, 0, 1, 0, 4'h8, 32'h0,       1, 32'h000000F1, 0, 0};
        vt[6]  = '{OP_LHU, 32'h1002, 32'h0,        32'h8001_0000, 1, 0, 1, 0, 4'hC, 32'h0,       1, 32'h00008001, 0, 0};
        vt[7]  = '{OP_LH,  32'h1000, 32'h0,        32'h0000_7FFF, 1, 0, 1, 0, 4'h3, 32'h0,       1, 32'h00007FFF, 0, 0};
        vt[8]  = '{OP_SH,  32'h2002, 32'h1234_BEEF, 32'h0,       1, 0, 1, 1, 4'hC, 32'hBEEFBEEF, 0, 32'h0,        0, 0};
        vt[9]  = '{OP_SW,  32'h2000, 32'h0102_0304, 32'h0,       1, 0, 1, 1, 4'hF, 32'h01020304, 0, 32'h0,        0, 0};
        vt[10] = '{OP_ALU, 32'h0,    32'h0000_0055, 32'h0,       0, 0, 0, 0, 4'h0, 32'h0,        1, 32'h00000055, 0, 0};
        vt[11] = '{OP_ALU, 32'h0,    32'h0000_0066, 32'h0,       0, 1, 0, 0, 4'h0, 32'h0,        0, 32'h0,        0, 0};
        vt[12] = '{OP_LW,  32'h1000, 32'h0,        32'h1234_5678, 1, 1, 0, 0, 4'h0, 32'h0,       0, 32'h0,        0, 0};
        vt[13] = '{OP_LH,  32'h1001, 32'h0,        32'h0,        0, 0, 0, 0, 4'h0, 32'h0,        0, 32'h0,        1, 0};
        vt[14] = '{OP_LB,  32'h1002, 32'h0,        32'h00FF_0000, 1, 0, 1, 0, 4'h4, 32'h0,       1, 32'hFFFFFFFF, 0, 0};
        ops = '{OP_NOP, OP_ALU, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

        // Reset state
        rst = 1'b0;
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset req", dbus_req, 0);
        check("reset stall", stallreq_mem, 0);
        check("reset wb_write", wb_wreg_write, 0);

        // Single-cycle vectors: FSM stays in IDLE for each one
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            drive(vt[i].op, vt[i].addr, vt[i].data, 1'b1, vt[i].data, vt[i].fl, vt[i].ack, vt[i].rdata);
            @(negedge clk);
            check($sformatf("v%0d req", i), dbus_req, vt[i].e_req);
            check($sformatf("v%0d stall", i), stallreq_mem, 0);
            check($sformatf("v%0d wb_write", i), wb_wreg_write, vt[i].e_wb);
            check($sformatf("v%0d adel", i), excp_adel, vt[i].e_adel);
            check($sformatf("v%0d ades", i), excp_ades, vt[i].e_ades);
            if (vt[i].e_req) begin
                check($sformatf("v%0d we", i), dbus_we, vt[i].e_we);
                check($sformatf("v%0d be", i), dbus_be, vt[i].e_be);
                check($sformatf("v%0d addr", i), dbus_addr, vt[i].addr & 32'hFFFF_FFFC);
            end
            if (vt[i].e_we) check($sformatf("v%0d wdata", i), dbus_wdata, vt[i].e_wdata);
            if (vt[i].e_wb) begin
                check($sformatf("v%0d wb_data", i), wb_wreg_data, vt[i].e_wbdata);
                check($sformatf("v%0d wb_addr", i), wb_wreg_addr, 7);
            end
            if (vt[i].e_adel || vt[i].e_ades) check($sformatf("v%0d bad_vaddr", i), bad_vaddr, vt[i].addr);
        end

        // LH with ack on the third request cycle
        begin
            int st;
            st = 0;
            next_cycle();
            drive(OP_LH, 32'h1002, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            st += int'(stallreq_mem);
            check("lh be", dbus_be, 4'b1100);
            check("lh req", dbus_req, 1);
            next_cycle();
            drive(OP_LH, 32'h1002, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h5555_5555);
            @(negedge clk);
            st += int'(stallreq_mem);
            check("lh wait addr", dbus_addr, 32'h1000);
            check("lh wait wb_write", wb_wreg_write, 0);
            next_cycle();
            drive(OP_LH, 32'h1002, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b1, 32'h8001_0000);
            @(negedge clk);
            st += int'(stallreq_mem);
            check("lh ack be", dbus_be, 4'b1100);
            next_cycle();
            drive(OP_LH, 32'h1002, 32'h0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h1234_5678);
            @(negedge clk);
            check("lh stall cycles", st, 3);
            check("lh done stall", stallreq_mem, 0);
            check("lh done req", dbus_req, 0);
            check("lh done wb_write", wb_wreg_write, 1);
            check("lh done wb_data", wb_wreg_data, 32'hFFFF_8001);
            next_cycle();
            drive(OP_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            check("lh idle req", dbus_req, 0);
            check("lh idle wb_write", wb_wreg_write, 0);
        end

        // Flushed LBU drains while a following LW waits
        next_cycle();
        drive(OP_LBU, 32'h4001, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("drain issue stall", stallreq_mem, 1);
        next_cycle();
        drive(OP_LBU, 32'h4001, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check("drain flush req", dbus_req, 1);
        next_cycle();
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("drain req held", dbus_req, 1);
        check("drain addr", dbus_addr, 32'h4000);
        check("drain be", dbus_be, 4'b0010);
        check("drain stall", stallreq_mem, 0);
        next_cycle();
        drive(OP_LW, 32'h5000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("drain lw stall", stallreq_mem, 1);
        check("drain lw addr", dbus_addr, 32'h4000);
        check("drain lw wb_write", wb_wreg_write, 0);
        next_cycle();
        drive(OP_LW, 32'h5000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0);
        @(negedge clk);
        check("drain ack stall", stallreq_mem, 1);
        check("drain ack wb_write", wb_wreg_write, 0);
        next_cycle();
        drive(OP_LW, 32'h5000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 32'h1122_3344);
        @(negedge clk);
        check("post drain addr", dbus_addr, 32'h5000);
        check("post drain stall", stallreq_mem, 0);
        check("post drain wb_data", wb_wreg_data, 32'h1122_3344);
        check("post drain wb_write", wb_wreg_write, 1);

        // Reset while waiting for ack
        next_cycle();
        drive(OP_LW, 32'h6000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rst wait stall", stallreq_mem, 1);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        drive(OP_NOP, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("rst abort req", dbus_req, 0);
        check("rst abort stall", stallreq_mem, 0);
        next_cycle();
        drive(OP_LW, 32'h7000, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hA1B2_C3D4);
        @(negedge clk);
        check("rst recover stall", stallreq_mem, 0);
        check("rst recover wb_data", wb_wreg_data, 32'hA1B2_C3D4);

        // Randomized transactions against the model
        for (int t = 0; t < 80; t++) begin
            Oper_t       op;
            logic [31:0] a, d, wd, ack_rd, wbv, addr0, wd0;
            logic        wr, ld, st, mem, mis, issue, we0, adel_s, ades_s;
            logic [3:0]  be0, e_be;
            int          lat, cyc, stalls, reqs, writes, unstable, nb, e_writes;
            bit          done;

            op  = ops[$urandom_range(0, 9)];
            a   = $urandom;
            d   = $urandom;
            wd  = $urandom;
            wr  = 1'($urandom_range(0, 1));
            lat = $urandom_range(0, 3);
            nb  = op_bytes(op);
            ld  = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
            st  = op inside {OP_SB, OP_SH, OP_SW};
            mem = ld || st;
            mis = mem && ((a % nb) != 0);
            issue = mem && !mis;
            e_be  = 4'(((1 << nb) - 1) << (a % 4));

            cyc = 0; stalls = 0; reqs = 0; writes = 0; unstable = 0;
            adel_s = 0; ades_s = 0; wbv = 0; ack_rd = 0;
            be0 = 0; we0 = 0; addr0 = 0; wd0 = 0;
            done = 0;
            while (!done) begin
                next_cycle();
                drive(op, a, d, wr, wd, 1'b0, issue && (cyc == lat), $urandom);
                if (dbus_ack) ack_rd = dbus_rdata;
                @(negedge clk);
                if (stallreq_mem) stalls++;
                if (dbus_req) begin
                    if (reqs == 0) begin
                        be0 = dbus_be; we0 = dbus_we; addr0 = dbus_addr; wd0 = dbus_wdata;
                    end else if (dbus_be != be0 || dbus_we != we0 || dbus_addr != addr0 || dbus_wdata != wd0) begin
                        unstable++;
                    end
                    reqs++;
                end
                if (wb_wreg_write) begin
                    writes++;
                    wbv = wb_wreg_data;
                end
                adel_s |= excp_adel;
                ades_s |= excp_ades;
                cyc++;
                if (!stallreq_mem) done = 1;
                else if (cyc > 10) begin
                    check($sformatf("r%0d timeout stall", t), stallreq_mem, 0);
                    done = 1;
                end
            end

            e_writes = (wr && ((ld && !mis) || !mem)) ? 1 : 0;
            check($sformatf("r%0d stalls", t), stalls, (issue && lat > 0) ? lat + 1 : 0);
            check($sformatf("r%0d reqs", t), reqs, issue ? lat + 1 : 0);
            check($sformatf("r%0d writes", t), writes, e_writes);
            check($sformatf("r%0d adel", t), adel_s, mis && ld);
            check($sformatf("r%0d ades", t), ades_s, mis && st);
            if (e_writes == 1) check($sformatf("r%0d wb_data", t), wbv, ld ? ref_load(op, a, ack_rd) : wd);
            if (issue) begin
                check($sformatf("r%0d be", t), be0, e_be);
                check($sformatf("r%0d we", t), we0, st);
                check($sformatf("r%0d addr", t), addr0, a - (a % 4));
                check($sformatf("r%0d stable", t), unstable, 0);
                if (st) check($sformatf("r%0d wdata", t), wd0,
                              (nb == 1) ? d[7:0] * 32'h0101_0101 :
                              (nb == 2) ? d[15:0] * 32'h0001_0001 : d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
